// File: rtl/kicker_gate_pattern_generator.sv
// Purpose: turns a single-cycle kicker gate strobe into a bit-resolution gate pulse, emitted as 8-bit words.
// Latency: strobe sampled at edge N gives the first pulse word on kgdGateBits after edge N+1; words are contiguous.
// Backpressure: none; a strobe arriving while a pulse is being emitted is dropped and counted in overrunCount.
module kicker_gate_pattern_generator #(
  parameter int PULSE_WIDTH_WIDTH = 16
) (
  input  logic                         kgdClk,
  input  logic                         kgdReset,
  input  logic                         kgdGateStrobe,
  input  logic                         cfgStrobe,
  input  logic [2:0]                   cfgOffset,
  input  logic [PULSE_WIDTH_WIDTH-1:0] cfgWidth,
  input  logic                         cfgInvert,
  output logic [7:0]                   kgdGateBits,
  output logic                         busy,
  output logic [7:0]                   overrunCount
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t state;
  state_t stateNext;

  // Pending configuration, written by the config interface at any time.
  logic [2:0]                   pOffset;
  logic [PULSE_WIDTH_WIDTH-1:0] pWidth;
  logic                         pInvert;

  // Active configuration, frozen while a pulse is in flight.
  logic [2:0]                   aOffset;
  logic [PULSE_WIDTH_WIDTH-1:0] aWidth;
  logic                         aInvert;

  // Pulse progress: bit position of the next rising edge and bits still to emit.
  logic [2:0]                   start;
  logic [PULSE_WIDTH_WIDTH-1:0] remaining;

  logic                         trigger;
  logic                         overrun;
  logic                         lastWord;
  logic [3:0]                   avail;
  logic [3:0]                   nBits;
  logic [PULSE_WIDTH_WIDTH-1:0] nBitsExt;
  logic [8:0]                   onesN;
  logic [7:0]                   wordBits;

  // Bits emitted this word: what fits above start, capped by what is left of the pulse.
  always_comb begin
    avail    = 4'd8 - {1'b0, start};
    nBits    = avail;
    if (remaining < {{(PULSE_WIDTH_WIDTH-4){1'b0}}, avail}) begin
      nBits = remaining[3:0];
    end
    nBitsExt = {{(PULSE_WIDTH_WIDTH-4){1'b0}}, nBits};
    lastWord = (remaining == nBitsExt);
    onesN    = (9'd1 << nBits) - 9'd1;
    wordBits = 8'h00;
    if (state == EMIT) begin
      wordBits = onesN[7:0] << start;
    end
  end

  // Next-state logic: start a pulse from IDLE on a strobe with non-zero width, flag overruns in EMIT.
  always_comb begin
    stateNext = state;
    trigger   = 1'b0;
    overrun   = 1'b0;
    case (state)
      IDLE: begin
        if (kgdGateStrobe && (aWidth != '0)) begin
          trigger   = 1'b1;
          stateNext = EMIT;
        end
      end
      EMIT: begin
        if (kgdGateStrobe) begin
          overrun = 1'b1;
        end
        if (lastWord) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge kgdClk) begin
    if (kgdReset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Pending configuration capture.
  always_ff @(posedge kgdClk) begin
    if (kgdReset) begin
      pOffset <= '0;
      pWidth  <= '0;
      pInvert <= 1'b0;
    end else if (cfgStrobe) begin
      pOffset <= cfgOffset;
      pWidth  <= cfgWidth;
      pInvert <= cfgInvert;
    end
  end

  // Active configuration follows pending only while idle, and holds across the triggering edge
  // so the pulse and its invert level always come from the same configuration.
  always_ff @(posedge kgdClk) begin
    if (kgdReset) begin
      aOffset <= '0;
      aWidth  <= '0;
      aInvert <= 1'b0;
    end else if ((state == IDLE) && !trigger) begin
      aOffset <= pOffset;
      aWidth  <= pWidth;
      aInvert <= pInvert;
    end
  end

  // Pulse progress: load on trigger, then consume up to one word of bits per cycle.
  always_ff @(posedge kgdClk) begin
    if (kgdReset) begin
      start     <= '0;
      remaining <= '0;
    end else if (trigger) begin
      start     <= aOffset;
      remaining <= aWidth;
    end else if (state == EMIT) begin
      start     <= '0;
      remaining <= remaining - nBitsExt;
    end
  end

  // Registered output word and busy flag for the serializer.
  always_ff @(posedge kgdClk) begin
    if (kgdReset) begin
      kgdGateBits <= 8'h00;
      busy        <= 1'b0;
    end else begin
      kgdGateBits <= wordBits ^ {8{aInvert}};
      busy        <= (state == EMIT);
    end
  end

  // Saturating count of dropped triggers.
  always_ff @(posedge kgdClk) begin
    if (kgdReset) begin
      overrunCount <= 8'h00;
    end else if (overrun && (overrunCount != 8'hFF)) begin
      overrunCount <= overrunCount + 8'd1;
    end
  end

endmodule
